// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: samples, then resolves one bit per settle+sync phase, MSB first.
// Every output is registered; cmp_in is synchronized before use and start is only looked at in IDLE.
module sar_adc_ctrl #(
   parameter int WIDTH         = 8,
   parameter int SAMPLE_CYCLES = 2,
   parameter int SETTLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic             cmp_in,
   output logic             sample_en,
   output logic [WIDTH-1:0] dac_code,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy
);

   localparam int T    = SETTLE_CYCLES + SYNC_STAGES;
   localparam int CMAX = (SAMPLE_CYCLES > T) ? SAMPLE_CYCLES : T;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [CW-1:0]    SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
   localparam logic [CW-1:0]    PHASE_LAST  = CW'(T - 1);
   localparam logic [BW-1:0]    MSB_IDX     = BW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAMPLE  = 2'd1,
      CONVERT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [WIDTH-1:0]       trial_q, trial_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sample_en_q, sample_en_d;
   logic [WIDTH-1:0]       dac_q, dac_d;
   logic [WIDTH-1:0]       result_q, result_d;
   logic                   done_q, done_d;
   logic                   busy_q, busy_d;

   logic                   cmp_s;
   logic [WIDTH-1:0]       kept;

   // Decisions only ever see the last synchronizer stage.
   assign cmp_s = sync_q[SYNC_STAGES-1];

   // Trial value with the bit under test kept or dropped by the comparator.
   assign kept = cmp_s ? (trial_q | (ONE << bit_q)) : trial_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_in};
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      trial_d     = trial_q;
      sample_en_d = 1'b0;
      dac_d       = '0;
      result_d    = result_q;
      done_d      = 1'b0;
      busy_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = SAMPLE;
               cnt_d       = '0;
               bit_d       = MSB_IDX;
               trial_d     = '0;
               sample_en_d = 1'b1;
               busy_d      = 1'b1;
            end
         end
         SAMPLE: begin
            busy_d = 1'b1;
            if (cnt_q == SAMPLE_LAST) begin
               state_d = CONVERT;
               cnt_d   = '0;
               bit_d   = MSB_IDX;
               dac_d   = ONE << MSB_IDX;
            end else begin
               cnt_d       = cnt_q + CW'(1);
               sample_en_d = 1'b1;
            end
         end
         CONVERT: begin
            busy_d = 1'b1;
            if (cnt_q == PHASE_LAST) begin
               trial_d = kept;
               cnt_d   = '0;
               if (bit_q == '0) begin
                  state_d  = DONE;
                  dac_d    = kept;
                  result_d = kept;
                  done_d   = 1'b1;
               end else begin
                  bit_d = bit_q - BW'(1);
                  dac_d = kept | (ONE << (bit_q - BW'(1)));
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
               dac_d = dac_q;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Disable overrides everything, including a decision landing in this same cycle.
      if (!ena) begin
         state_d     = IDLE;
         cnt_d       = '0;
         sample_en_d = 1'b0;
         dac_d       = '0;
         result_d    = result_q;
         done_d      = 1'b0;
         busy_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         trial_q     <= '0;
         sample_en_q <= 1'b0;
         dac_q       <= '0;
         result_q    <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         trial_q     <= trial_d;
         sample_en_q <= sample_en_d;
         dac_q       <= dac_d;
         result_q    <= result_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign sample_en = sample_en_q;
   assign dac_code  = dac_q;
   assign result    = result_q;
   assign done      = done_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: default 8-bit instance plus a 6-bit, SETTLE_CYCLES=1 instance.
module tb_sar_adc_ctrl;

   localparam int W   = 8;
   localparam int SC  = 2;
   localparam int T   = 4 + 2;
   localparam int LAT = SC + W * T + 1;      // 51
   localparam int W2  = 6;
   localparam int T2  = 1 + 2;
   localparam int LAT2 = SC + W2 * T2 + 1;   // 21

   logic          clk = 1'b0;
   logic          rst_n, ena, start, cmp_in;
   logic          sample_en, done, busy;
   logic [W-1:0]  dac_code, result;

   logic          ena2, start2, cmp2;
   logic          sample_en2, done2, busy2;
   logic [W2-1:0] dac2, res2;

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;

   int            mode;     // 0: comparator model, 1: cmp_v drives cmp_in
   logic [W-1:0]  vin;
   logic          cmp_v;
   logic [W2-1:0] vin2;

   logic [W-1:0]  trials [8];
   int            done_cyc, done_w;
   logic [31:0]   se_mask;

   assign cmp_in = (mode == 0) ? (vin >= dac_code) : cmp_v;
   assign cmp2   = (vin2 >= dac2);

   always #5 clk = ~clk;

   sar_adc_ctrl dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cmp_in(cmp_in),
      .sample_en(sample_en), .dac_code(dac_code), .result(result),
      .done(done), .busy(busy)
   );

   sar_adc_ctrl #(.WIDTH(W2), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(1), .SYNC_STAGES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .ena(ena2), .start(start2), .cmp_in(cmp2),
      .sample_en(sample_en2), .dac_code(dac2), .result(res2),
      .done(done2), .busy(busy2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Presents start for one edge; afterwards the bench is in cycle 1 of the conversion.
   task automatic accept(input logic keep_start);
      start = 1'b1;
      @(posedge clk);
      #1;
      cyc = 1;
      if (!keep_start) start = 1'b0;
   endtask

   // Runs until the done pulse ends (or the budget expires), recording trials and timing.
   task automatic run_to_done(input int budget);
      int idx;
      idx = 0;
      done_cyc = -1;
      done_w = 0;
      se_mask = '0;
      for (int n = 0; n < budget; n++) begin
         if (sample_en && cyc < 32) se_mask[cyc] = 1'b1;
         if (idx < 8 && cyc == SC + 1 + idx * T) begin
            trials[idx] = dac_code;
            idx++;
         end
         if (done) begin
            if (done_cyc < 0) done_cyc = cyc;
            done_w++;
         end else if (done_cyc >= 0) begin
            break;
         end
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [W-1:0] exp_trials [8];
      logic [W-1:0] dres [3];
      int           dcyc [3];
      int           nd, ndone;
      logic [W-1:0] mid;

      exp_trials = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

      rst_n = 1'b0; ena = 1'b1; start = 1'b0;
      ena2 = 1'b1; start2 = 1'b0; vin2 = '0;
      mode = 0; vin = '0; cmp_v = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {sample_en, done, busy, dac_code, result}, '0);
      rst_n = 1'b1;
      tick(); tick();
      chk("idle_after_reset", {busy, dac_code}, '0);

      // ena low blocks acceptance of start
      ena = 1'b0; start = 1'b1;
      tick(); tick(); tick();
      chk("no_start_when_disabled", busy, 0);
      ena = 1'b1; start = 1'b0;
      tick();

      // nominal 0xA5
      vin = 8'hA5;
      accept(1'b0);
      run_to_done(80);
      for (int i = 0; i < 8; i++) chk($sformatf("nominal_trial%0d", i), trials[i], exp_trials[i]);
      chk("nominal_done_cycle", done_cyc, LAT);
      chk("nominal_done_width", done_w, 1);
      chk("nominal_sample_cycles", se_mask, 32'h6);
      chk("nominal_result", result, 8'hA5);
      chk("nominal_idle_after", {busy, dac_code}, '0);

      // asynchronous reset mid-CONVERT
      accept(1'b0);
      while (cyc < SC + 1 + T) tick();
      chk("pre_reset_dac", dac_code, 8'hC0);
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {sample_en, done, busy, dac_code, result}, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("reset_release_idle", {busy, result}, '0);

      // extremes
      mode = 1; cmp_v = 1'b1;
      accept(1'b0);
      run_to_done(80);
      chk("tie1_result", result, 8'hFF);
      chk("tie1_done_cycle", done_cyc, LAT);
      chk("tie1_done_width", done_w, 1);
      cmp_v = 1'b0;
      accept(1'b0);
      run_to_done(80);
      chk("tie0_result", result, 8'h00);
      chk("tie0_done_width", done_w, 1);
      mode = 0; vin = 8'h01;
      accept(1'b0);
      run_to_done(80);
      chk("code01_result", result, 8'h01);
      chk("code01_done_width", done_w, 1);

      // continuous conversions with start held high
      vin = 8'h3C; nd = 0; mid = '0;
      dcyc = '{-1, -1, -1};
      dres = '{8'h00, 8'h00, 8'h00};
      accept(1'b1);
      for (int n = 0; n < 220 && nd < 3; n++) begin
         if (done) begin
            dcyc[nd] = cyc;
            dres[nd] = result;
            nd++;
            if (nd == 2) vin = 8'hF0;
         end
         if (cyc == 140) mid = result;
         tick();
      end
      start = 1'b0;
      chk("cont_done0_cycle", dcyc[0], LAT);
      chk("cont_done1_cycle", dcyc[1], LAT + 52);
      chk("cont_done2_cycle", dcyc[2], LAT + 104);
      chk("cont_result0", dres[0], 8'h3C);
      chk("cont_result1", dres[1], 8'h3C);
      chk("cont_result2", dres[2], 8'hF0);
      chk("cont_result_stable_mid", mid, 8'h3C);
      tick(); tick();

      // comparator high only in the MSB decision cycle is not seen
      mode = 1; cmp_v = 1'b0;
      accept(1'b0);
      while (cyc < SC + T) tick();
      cmp_v = 1'b1;
      tick();
      cmp_v = 1'b0;
      run_to_done(80);
      chk("sync_short_pulse_result", result, 8'h00);
      chk("sync_short_pulse_done", done_cyc, LAT);
      // held through the synchronizer window it is seen
      accept(1'b0);
      while (cyc < SC + T - 2) tick();
      cmp_v = 1'b1;
      tick(); tick(); tick();
      cmp_v = 1'b0;
      run_to_done(80);
      chk("sync_held_result", result, 8'h80);

      // 6-bit, SETTLE_CYCLES=1 instance
      vin2 = 6'h2B;
      start2 = 1'b1;
      @(posedge clk);
      #1;
      cyc = 1;
      start2 = 1'b0;
      done_cyc = -1;
      for (int n = 0; n < 60 && done_cyc < 0; n++) begin
         if (done2) done_cyc = cyc;
         else tick();
      end
      chk("w6_latency", done_cyc, LAT2);
      chk("w6_result", res2, 6'h2B);
      tick(); tick();

      // enable drop at conversion cycle 30
      mode = 0; vin = 8'h5A;
      accept(1'b0);
      run_to_done(80);
      chk("ena_prior_result", result, 8'h5A);
      vin = 8'h33;
      accept(1'b0);
      while (cyc < 30) tick();
      ena = 1'b0;
      tick();
      ena = 1'b1;
      chk("ena_drop_idle", {sample_en, busy, dac_code}, '0);
      ndone = 0;
      for (int n = 0; n < 60; n++) begin
         if (done) ndone++;
         tick();
      end
      chk("ena_drop_no_done", ndone, 0);
      chk("ena_drop_result_kept", result, 8'h5A);
      accept(1'b0);
      run_to_done(80);
      chk("ena_restart_result", result, 8'h33);
      chk("ena_restart_done_cycle", done_cyc, LAT);

      // ena drop coinciding with the final decision
      vin = 8'h11;
      accept(1'b0);
      while (cyc < LAT - 1) tick();
      ena = 1'b0;
      tick();
      ena = 1'b1;
      ndone = 0;
      for (int n = 0; n < 5; n++) begin
         if (done) ndone++;
         tick();
      end
      chk("ena_final_no_done", ndone, 0);
      chk("ena_final_result_kept", result, 8'h33);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
